// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory behind a valid/ready load/store port.
// Handles byte/half/word accesses with lane merging on stores and sign/zero
// extension on loads. Only one request is in flight; its response follows
// after LATENCY cycles.
// Optional feature: define DMEM_INIT_CLEAR_EN to zero the whole array after
// every reset before the first request is accepted.
module dmem_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;
   // Value of the BUSY cycle counter on the last BUSY cycle.
   localparam logic [1:0]  BUSY_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

`ifdef DMEM_INIT_CLEAR_EN
   typedef enum logic [1:0] {StClear, StIdle, StBusy, StResp} state_e;
   localparam state_e RESET_STATE = StClear;
`else
   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
   localparam state_e RESET_STATE = StIdle;
`endif

   state_e state_q, state_d;
   logic [1:0] lat_q, lat_d;
   logic       ready_q;

   logic [31:0] mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  accept;
   logic                  req_bad;
   logic [3:0]            be;
   logic [31:0]           wword;
   logic [31:0]           mem_rd;
   logic [31:0]           merged;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [31:0]           mem_wdata;

   // Request captured at the accept edge and held until the response.
   logic [31:0] word_q;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        we_q;
   logic        err_q;

   logic [31:0] shifted;
   logic [31:0] load_ext;

   assign word_idx  = req_addr[ADDR_WIDTH+1:2];
   assign lane      = req_addr[1:0];
   assign req_ready = ready_q;
   assign accept    = req_valid && ready_q;
   assign mem_rd    = mem[word_idx];

`ifdef DMEM_INIT_CLEAR_EN
   logic [ADDR_WIDTH-1:0] sweep_q;

   // Sweep pointer walks the array once while in CLEAR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sweep_q <= '0;
      end else if (state_q == StClear) begin
         sweep_q <= sweep_q + ADDR_WIDTH'(1);
      end
   end
`endif

   // Fault classification; any hit suppresses the write and the load data.
   always_comb begin
      req_bad = 1'b0;
      if (req_size == 2'b11) begin
         req_bad = 1'b1;
      end else if (req_size == 2'b01 && req_addr[0]) begin
         req_bad = 1'b1;
      end else if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
         req_bad = 1'b1;
      end else if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
         req_bad = 1'b1;
      end
   end

   // Byte-enable mask and lane-replicated store data, merged with the old word.
   always_comb begin
      be    = 4'b0000;
      wword = req_wdata;
      case (req_size)
         2'b00: begin
            be    = 4'b0001 << lane;
            wword = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{req_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? wword[8*i +: 8] : mem_rd[8*i +: 8];
      end
   end

   // Single write port shared by committed stores and the clear sweep.
   always_comb begin
      mem_we    = accept && req_we && !req_bad;
      mem_waddr = word_idx;
      mem_wdata = merged;
`ifdef DMEM_INIT_CLEAR_EN
      if (state_q == StClear && !reset) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_q;
         mem_wdata = 32'd0;
      end
`endif
   end

   // Memory array; deliberately not reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // State register; ready is registered so it stays low during and right after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RESET_STATE;
         lat_q   <= 2'd0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         ready_q <= (state_d == StIdle);
      end
   end

   // Next-state logic: accept, wait out the latency, one response cycle.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
         StClear: if (&sweep_q) state_d = StIdle;
`endif
         StIdle: begin
            if (accept) begin
               state_d = (LATENCY > 1) ? StBusy : StResp;
               lat_d   = 2'd0;
            end
         end
         StBusy: begin
            if (lat_q == BUSY_LAST) begin
               state_d = StResp;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = RESET_STATE;
      endcase
   end

   // Capture the addressed word and access attributes at the accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= 32'd0;
         lane_q <= 2'd0;
         size_q <= 2'd0;
         uns_q  <= 1'b0;
         we_q   <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         word_q <= mem_rd;
         lane_q <= lane;
         size_q <= req_size;
         uns_q  <= req_unsigned;
         we_q   <= req_we;
         err_q  <= req_bad;
      end
   end

   // Shift the selected lane(s) down and extend to 32 bits.
   always_comb begin
      shifted = word_q >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = word_q;
      endcase
   end

   // Response outputs are forced to zero outside the response cycle.
   always_comb begin
      resp_valid = (state_q == StResp);
      resp_err   = resp_valid && err_q;
      resp_rdata = 32'd0;
      if (resp_valid && !err_q && !we_q) begin
         resp_rdata = load_ext;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed table, randomized traffic against a byte-level
// memory model, latency/throughput and asynchronous-reset sequences.
// Two instances: LATENCY=1 (dut1) and LATENCY=3 (dut3).
module tb_dmem_ctrl;

   logic        clk;
   logic        reset1, reset3;
   logic        req_valid1, req_valid3;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready1, req_ready3;
   logic        resp_valid1, resp_valid3;
   logic [31:0] resp_rdata1, resp_rdata3;
   logic        resp_err1, resp_err3;

   int nvec = 0;
   int nbad = 0;
   bit sel  = 1'b0;

   // Byte-addressed reference memory covering the 4 KiB range.
   logic [7:0] mb [4096];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[21];

   dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .clk          (clk),
      .reset        (reset1),
      .req_valid    (req_valid1),
      .req_ready    (req_ready1),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid1),
      .resp_rdata   (resp_rdata1),
      .resp_err     (resp_err1)
   );

   dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
      .clk          (clk),
      .reset        (reset3),
      .req_valid    (req_valid3),
      .req_ready    (req_ready3),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid3),
      .resp_rdata   (resp_rdata3),
      .resp_err     (resp_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic cur_ready();
      return sel ? req_ready3 : req_ready1;
   endfunction
   function automatic logic cur_rv();
      return sel ? resp_valid3 : resp_valid1;
   endfunction
   function automatic logic [31:0] cur_rd();
      return sel ? resp_rdata3 : resp_rdata1;
   endfunction
   function automatic logic cur_err();
      return sel ? resp_err3 : resp_err1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference rules: size code -> byte count; natural alignment; 4 KiB range.
   function automatic bit mdl_err(input logic [1:0] size, input logic [31:0] addr);
      int unsigned nb;
      if (size == 2'd3) return 1'b1;
      nb = 1 << size;
      if ((addr % nb) != 0) return 1'b1;
      if (addr >= 32'd4096) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
      int unsigned nb;
      longint val;
      nb  = 1 << size;
      val = 0;
      for (int k = 0; k < int'(nb); k++) val += longint'(mb[addr + k]) << (8 * k);
      if (!uns && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) val -= longint'(1) << (8 * nb);
      return 32'(val);
   endfunction

   task automatic mdl_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
      int unsigned nb;
      nb = 1 << size;
      for (int k = 0; k < int'(nb); k++) mb[addr + k] = 8'(wdata >> (8 * k));
   endtask

   // One complete transaction on the selected DUT, with latency and pulse checks.
   task automatic run(input bit s, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string nm);
      int n;
      int lat;
      sel = s;
      n = 0;
      while (!cur_ready() && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!cur_ready()) begin
         chk({nm, " ready_timeout"}, 32'(cur_ready()), 32'd1);
         return;
      end
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid1   = (s == 1'b0);
      req_valid3   = (s == 1'b1);
      @(posedge clk);
      #1;
      req_valid1   = 1'b0;
      req_valid3   = 1'b0;
      // Scramble fields: the DUT must only use what it sampled at the accept edge.
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      lat = 1;
      while (!cur_rv() && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), s ? 32'd3 : 32'd1);
      chk({nm, " rdata"}, cur_rd(), exp_rd);
      chk({nm, " err"}, 32'(cur_err()), 32'(exp_err));
      @(posedge clk);
      #1;
      chk({nm, " after {valid,err,ready}"}, {29'd0, cur_rv(), cur_err(), cur_ready()}, 32'd1);
      chk({nm, " after rdata"}, cur_rd(), 32'd0);
   endtask

   initial begin
      logic [31:0] a, wd, er_rd;
      logic [1:0]  sz;
      logic        we, un, er;
      int          n, cnt;
      logic        rr [17];
      logic        rv [17];
      logic [31:0] rd [17];

      reset1 = 1'b1;
      reset3 = 1'b1;
      req_valid1 = 1'b0;
      req_valid3 = 1'b0;
      req_we = 1'b0;
      req_size = 2'd0;
      req_unsigned = 1'b0;
      req_addr = 32'd0;
      req_wdata = 32'd0;
`ifdef DMEM_INIT_CLEAR_EN
      for (int i = 0; i < 4096; i++) mb[i] = 8'd0;
`endif

      tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h3C,   32'hCAFEBABE, 32'h00000000, 1'b0};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h3C,   32'h0,        32'hCAFEBABE, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h3D,   32'h0,        32'hFFFFFFBA, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h3F,   32'h0,        32'h000000CA, 1'b0};
      tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h3E,   32'h0,        32'hFFFFCAFE, 1'b0};
      tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h3C,   32'h0,        32'h0000BABE, 1'b0};
      tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h3E,   32'hABCDEF11, 32'h00000000, 1'b0};
      tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h3C,   32'h0,        32'hCA11BABE, 1'b0};
      tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h3C,   32'h98761234, 32'h00000000, 1'b0};
      tbl[9]  = '{1'b0, 2'd2, 1'b1, 32'h3C,   32'h0,        32'hCA111234, 1'b0};
      tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h3D,   32'h0,        32'h00000000, 1'b1};
      tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h40,   32'h55AA33CC, 32'h00000000, 1'b0};
      tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h41,   32'h0000FFFF, 32'h00000000, 1'b1};
      tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h55AA33CC, 1'b0};
      tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1};
      tbl[15] = '{1'b0, 2'd3, 1'b0, 32'h40,   32'h0,        32'h00000000, 1'b1};
      tbl[16] = '{1'b0, 2'd0, 1'b0, 32'h3C,   32'h0,        32'h00000034, 1'b0};
      tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h42,   32'h0,        32'h000055AA, 1'b0};
      tbl[18] = '{1'b1, 2'd3, 1'b0, 32'h40,   32'h0,        32'h00000000, 1'b1};
      tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h55AA33CC, 1'b0};
      tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h2000, 32'h77,       32'h00000000, 1'b1};

      // Outputs while reset is held.
      #1;
      chk("reset ready1", 32'(req_ready1), 32'd0);
      chk("reset valid1", 32'(resp_valid1), 32'd0);
      chk("reset rdata1", resp_rdata1, 32'd0);
      chk("reset err1", 32'(resp_err1), 32'd0);
      chk("reset ready3", 32'(req_ready3), 32'd0);
      chk("reset valid3", 32'(resp_valid3), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      reset3 = 1'b0;

      n = 0;
      while (!req_ready1 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
`ifdef DMEM_INIT_CLEAR_EN
      chk("ready delay after reset", 32'(n), 32'd1024);
      run(1'b0, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, "cleared lw 0x3C");
`else
      chk("ready delay after reset", 32'(n), 32'd1);
`endif

      // Directed table on the LATENCY=1 instance.
      for (int i = 0; i < 21; i++) begin
         run(1'b0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rd, tbl[i].exp_err, $sformatf("tbl[%0d]", i));
         if (tbl[i].we && !mdl_err(tbl[i].size, tbl[i].addr))
            mdl_store(tbl[i].size, tbl[i].addr, tbl[i].wdata);
      end

      // Randomized traffic: seed words 32..47 first, then mixed accesses.
      for (int w = 32; w < 48; w++) begin
         wd = $urandom;
         run(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), wd, 32'h0, 1'b0, $sformatf("seed w%0d", w));
         mdl_store(2'd2, 32'(w * 4), wd);
      end
      for (int t = 0; t < 150; t++) begin
         we = 1'($urandom);
         un = 1'($urandom);
         wd = $urandom;
         sz = 2'($urandom_range(0, 2));
         a  = 32'h80 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = 32'h1000 | ($urandom & 32'hFFFF_F000);
         if ($urandom_range(0, 15) == 0) sz = 2'd3;
         er = mdl_err(sz, a);
         if (er || we) er_rd = 32'h0;
         else er_rd = mdl_load(sz, un, a);
         run(1'b0, we, sz, un, a, wd, er_rd, er, $sformatf("rand[%0d]", t));
         if (we && !er) mdl_store(sz, a, wd);
      end

      // Asynchronous reset during the response cycle must clear outputs at once.
      sel = 1'b0;
      n = 0;
      while (!req_ready1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_we = 1'b0;
      req_size = 2'd2;
      req_unsigned = 1'b0;
      req_addr = 32'h3C;
      req_valid1 = 1'b1;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      chk("rst_resp pre valid", 32'(resp_valid1), 32'd1);
      chk("rst_resp pre rdata", resp_rdata1, 32'hCA111234);
      #2;
      reset1 = 1'b1;
      #1;
      chk("rst_resp {valid,err,ready}", {29'd0, resp_valid1, resp_err1, req_ready1}, 32'd0);
      chk("rst_resp rdata", resp_rdata1, 32'd0);
      @(negedge clk);
      reset1 = 1'b0;

      // LATENCY=3: back-to-back throughput with req_valid held high.
      run(1'b1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h13579BDF, 32'h0, 1'b0, "l3 sw 0x80");
      @(negedge clk);
      req_we = 1'b0;
      req_size = 2'd2;
      req_unsigned = 1'b0;
      req_addr = 32'h80;
      req_valid3 = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         rr[c] = req_ready3;
         rv[c] = resp_valid3;
         rd[c] = resp_rdata3;
      end
      req_valid3 = 1'b0;
      // Accepts land on edges 1, 5, 9, 13.
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("l3 stream valid edge %0d", c), 32'(rv[c]), 32'(((c - 1) % 4) == 2));
         chk($sformatf("l3 stream ready edge %0d", c), 32'(rr[c]), 32'(((c - 1) % 4) == 3));
         chk($sformatf("l3 stream rdata edge %0d", c), rd[c],
             (((c - 1) % 4) == 2) ? 32'h13579BDF : 32'h0);
      end
      @(posedge clk);
      #1;

      // LATENCY=3: reset while BUSY drops the request and produces no response.
      run(1'b1, 1'b1, 2'd2, 1'b0, 32'h84, 32'hDEADBEEF, 32'h0, 1'b0, "l3 sw 0x84");
      sel = 1'b1;
      req_we = 1'b0;
      req_size = 2'd2;
      req_addr = 32'h84;
      req_valid3 = 1'b1;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      #2;
      reset3 = 1'b1;
      #1;
      chk("rst_busy {valid,err,ready}", {29'd0, resp_valid3, resp_err3, req_ready3}, 32'd0);
      chk("rst_busy rdata", resp_rdata3, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset3 = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (resp_valid3) cnt++;
      end
      chk("rst_busy no response", 32'(cnt), 32'd0);
`ifdef DMEM_INIT_CLEAR_EN
      run(1'b1, 1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 32'h00000000, 1'b0, "l3 lw after reset");
`else
      run(1'b1, 1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 32'hDEADBEEF, 1'b0, "l3 lw after reset");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
